// File: rtl/obi_core_port_arbiter.sv
// obi_core_port_arbiter
// Shares one OBI slave port between the instruction master (M0) and the data
// master (M1). The address phase is arbitrated round-robin (or fixed priority
// to M1), with the selection locked while a request waits for its grant.
// Accepted transactions are recorded in an in-order ID FIFO, and each response
// is routed back to the master at the FIFO head.
module obi_core_port_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter bit FIXED_PRIO      = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       m_req_i,
    input  logic [1:0][31:0] m_addr_i,
    input  logic [1:0]       m_we_i,
    input  logic [1:0][3:0]  m_be_i,
    input  logic [1:0][31:0] m_wdata_i,
    output logic [1:0]       m_gnt_o,
    output logic [1:0]       m_rvalid_o,
    output logic [31:0]      m_rdata_o,
    output logic             s_req_o,
    output logic [31:0]      s_addr_o,
    output logic             s_we_o,
    output logic [3:0]       s_be_o,
    output logic [31:0]      s_wdata_o,
    input  logic             s_gnt_i,
    input  logic             s_rvalid_i,
    input  logic [31:0]      s_rdata_i,
    output logic [3:0]       outstanding_o,
    output logic             rvalid_err_o
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [3:0] CNT_FULL = 4'(MAX_OUTSTANDING);

    // Arbitration state
    logic             lock_q;
    logic             locked_sel_q;
    logic             last_winner_q;

    // In-order ID FIFO: one bit per entry naming the issuing master
    logic             fifo_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [3:0]       count_q;
    logic             err_q;

    logic sel;
    logic fifo_full;
    logic fifo_empty;
    logic handshake;
    logic pop;
    logic head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign fifo_full  = (count_q == CNT_FULL);
    assign fifo_empty = (count_q == 4'd0);
    assign head       = fifo_mem[rd_ptr_q];

    // Pick the master that owns the address phase this cycle
    always_comb begin
        sel = ~last_winner_q;
        if (lock_q) begin
            sel = locked_sel_q;
        end else if (m_req_i == 2'b01) begin
            sel = 1'b0;
        end else if (m_req_i == 2'b10) begin
            sel = 1'b1;
        end else if (m_req_i == 2'b11) begin
            sel = FIXED_PRIO ? 1'b1 : ~last_winner_q;
        end
    end

    // Address phase, grant routing and response routing (all combinational)
    always_comb begin
        s_req_o    = ~rst_i & m_req_i[sel] & ~fifo_full;
        s_addr_o   = m_addr_i[sel];
        s_we_o     = m_we_i[sel];
        s_be_o     = m_be_i[sel];
        s_wdata_o  = m_wdata_i[sel];
        handshake  = s_req_o & s_gnt_i;
        pop        = ~rst_i & s_rvalid_i & ~fifo_empty;
        m_gnt_o    = 2'b00;
        m_gnt_o[sel] = handshake;
        m_rvalid_o = 2'b00;
        m_rvalid_o[head] = pop;
        m_rdata_o  = s_rdata_i;
    end

    // Lock and round-robin history; a full FIFO freezes the lock as it stands
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q        <= 1'b0;
            locked_sel_q  <= 1'b0;
            last_winner_q <= 1'b1;
        end else if (handshake) begin
            lock_q        <= 1'b0;
            last_winner_q <= sel;
        end else if (!fifo_full) begin
            if (s_req_o) begin
                lock_q       <= 1'b1;
                locked_sel_q <= sel;
            end else if (lock_q) begin
                // Locked master withdrew its request: release the lock
                lock_q <= 1'b0;
            end
        end
    end

    // ID FIFO pointers, occupancy and the sticky stray-rvalid flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= 4'd0;
            err_q    <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (handshake) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            count_q <= count_q + {3'b000, handshake} - {3'b000, pop};
            if (s_rvalid_i && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    // ID storage holds data only, so it carries no reset
    always_ff @(posedge clk_i) begin
        if (handshake) begin
            fifo_mem[wr_ptr_q] <= sel;
        end
    end

    assign outstanding_o = count_q;
    assign rvalid_err_o  = err_q;

endmodule

// File: tb/tb_obi_core_port_arbiter.sv
// Bench for obi_core_port_arbiter: a queue-based model of the arbiter is checked
// against the DUT every cycle, and directed scenarios pin the model with
// hand-computed expectations.
module tb_obi_core_port_arbiter;

    localparam int MAXO = 2;
    localparam bit FP   = 1'b0;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       m_req = 2'b00;
    logic [1:0][31:0] m_addr = '0;
    logic [1:0]       m_we = 2'b00;
    logic [1:0][3:0]  m_be = '0;
    logic [1:0][31:0] m_wdata = '0;
    logic [1:0]       m_gnt;
    logic [1:0]       m_rvalid;
    logic [31:0]      m_rdata;
    logic             s_req;
    logic [31:0]      s_addr;
    logic             s_we;
    logic [3:0]       s_be;
    logic [31:0]      s_wdata;
    logic             s_gnt = 1'b0;
    logic             s_rvalid = 1'b0;
    logic [31:0]      s_rdata = '0;
    logic [3:0]       outstanding;
    logic             rvalid_err;

    int checks = 0;
    int errors = 0;

    obi_core_port_arbiter #(
        .MAX_OUTSTANDING(MAXO),
        .FIXED_PRIO     (FP)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .m_req_i      (m_req),
        .m_addr_i     (m_addr),
        .m_we_i       (m_we),
        .m_be_i       (m_be),
        .m_wdata_i    (m_wdata),
        .m_gnt_o      (m_gnt),
        .m_rvalid_o   (m_rvalid),
        .m_rdata_o    (m_rdata),
        .s_req_o      (s_req),
        .s_addr_o     (s_addr),
        .s_we_o       (s_we),
        .s_be_o       (s_be),
        .s_wdata_o    (s_wdata),
        .s_gnt_i      (s_gnt),
        .s_rvalid_i   (s_rvalid),
        .s_rdata_i    (s_rdata),
        .outstanding_o(outstanding),
        .rvalid_err_o (rvalid_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: outstanding master IDs in issue order, plus arbitration history
    int q[$];
    bit lk    = 1'b0;
    int lsel  = 0;
    int lastw = 1;
    bit merr  = 1'b0;

    // Compare outputs with the model mid-cycle, then advance the model
    always @(negedge clk) begin
        int w;
        bit full;
        bit esreq;
        bit hs;
        logic [1:0] egnt;
        logic [1:0] erv;
        chk("outstanding", 32'(outstanding), 32'(q.size()));
        chk("rvalid_err", 32'(rvalid_err), 32'(merr));
        chk("rdata", m_rdata, s_rdata);
        if (rst) begin
            chk("rst_s_req", 32'(s_req), 32'd0);
            chk("rst_gnt", 32'(m_gnt), 32'd0);
            chk("rst_rvalid", 32'(m_rvalid), 32'd0);
            q.delete();
            lk    = 1'b0;
            lastw = 1;
            merr  = 1'b0;
        end else begin
            full = (q.size() == MAXO);
            if (lk) w = lsel;
            else if (m_req == 2'b01) w = 0;
            else if (m_req == 2'b10) w = 1;
            else if (m_req == 2'b11) w = FP ? 1 : 1 - lastw;
            else w = -1;
            esreq = 1'b0;
            if (w >= 0) esreq = m_req[w] && !full;
            hs   = esreq && s_gnt;
            egnt = 2'b00;
            if (hs) egnt[w] = 1'b1;
            erv = 2'b00;
            if (s_rvalid && q.size() > 0) erv[q[0]] = 1'b1;
            chk("s_req", 32'(s_req), 32'(esreq));
            chk("gnt", 32'(m_gnt), 32'(egnt));
            chk("rvalid", 32'(m_rvalid), 32'(erv));
            if (esreq) begin
                chk("s_addr", s_addr, m_addr[w]);
                chk("s_we", 32'(s_we), 32'(m_we[w]));
                chk("s_be", 32'(s_be), 32'(m_be[w]));
                chk("s_wdata", s_wdata, m_wdata[w]);
            end
            if (s_rvalid) begin
                if (q.size() > 0) void'(q.pop_front());
                else merr = 1'b1;
            end
            if (hs) begin
                q.push_back(w);
                lastw = w;
                lk    = 1'b0;
            end else if (!full) begin
                if (esreq) begin
                    lk   = 1'b1;
                    lsel = w;
                end else begin
                    lk = 1'b0;
                end
            end
        end
    end

    // Apply one cycle of inputs just after the edge, return mid-cycle
    task automatic drive(input logic r, input logic [1:0] rq, input logic g,
                         input logic rv, input logic [31:0] rd);
        @(posedge clk);
        #1;
        rst      = r;
        m_req    = rq;
        s_gnt    = g;
        s_rvalid = rv;
        s_rdata  = rd;
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        m_addr[0]  = 32'h0000_0180;
        m_addr[1]  = 32'h0000_2000;
        m_be[0]    = 4'hF;
        m_be[1]    = 4'h3;
        m_wdata[0] = 32'h1111_0000;
        m_wdata[1] = 32'h2222_5555;
        m_we       = 2'b00;

        drive(1, 2'b00, 0, 0, 0);
        drive(1, 2'b00, 0, 0, 0);
        chk("reset_outstanding", 32'(outstanding), 32'd0);
        chk("reset_err", 32'(rvalid_err), 32'd0);

        // Single M0 read
        drive(0, 2'b01, 1, 0, 0);
        chk("t1_gnt", 32'(m_gnt), 32'h1);
        chk("t1_addr", s_addr, 32'h180);
        chk("t1_occ0", 32'(outstanding), 32'd0);
        drive(0, 2'b00, 0, 1, 32'hDEAD_BEEF);
        chk("t1_occ1", 32'(outstanding), 32'd1);
        chk("t1_rvalid", 32'(m_rvalid), 32'h1);
        chk("t1_rdata", m_rdata, 32'hDEAD_BEEF);
        drive(0, 2'b00, 0, 0, 0);
        chk("t1_occ_end", 32'(outstanding), 32'd0);

        // Round-robin alternation from a fresh reset
        drive(1, 2'b00, 0, 0, 0);
        m_addr[0] = 32'h0000_1000;
        drive(0, 2'b11, 1, 0, 0);
        chk("t2_g0", 32'(m_gnt), 32'h1);
        drive(0, 2'b11, 1, 1, 32'hA0A0_0001);
        chk("t2_g1", 32'(m_gnt), 32'h2);
        chk("t2_r1", 32'(m_rvalid), 32'h1);
        drive(0, 2'b11, 1, 1, 32'hA0A0_0002);
        chk("t2_g2", 32'(m_gnt), 32'h1);
        chk("t2_r2", 32'(m_rvalid), 32'h2);
        drive(0, 2'b11, 1, 1, 32'hA0A0_0003);
        chk("t2_g3", 32'(m_gnt), 32'h2);
        chk("t2_r3", 32'(m_rvalid), 32'h1);
        drive(0, 2'b01, 1, 1, 32'hA0A0_0004);
        chk("t2_g4", 32'(m_gnt), 32'h1);
        chk("t2_r4", 32'(m_rvalid), 32'h2);
        drive(0, 2'b00, 0, 1, 32'hA0A0_0005);
        chk("t2_r5", 32'(m_rvalid), 32'h1);

        // M1 write held by slave back-pressure while M0 also requests
        m_we = 2'b10;
        for (int i = 0; i < 3; i++) begin
            drive(0, 2'b11, 0, 0, 0);
            chk("t3_addr", s_addr, 32'h2000);
            chk("t3_we", 32'(s_we), 32'd1);
            chk("t3_nogrant", 32'(m_gnt), 32'h0);
        end
        drive(0, 2'b11, 1, 0, 0);
        chk("t3_grant", 32'(m_gnt), 32'h2);
        drive(0, 2'b00, 0, 1, 32'h0BAD_F00D);
        m_we = 2'b00;

        // FIFO fills with delayed responses, then drains
        drive(0, 2'b01, 1, 0, 0);
        drive(0, 2'b01, 1, 0, 0);
        drive(0, 2'b01, 1, 0, 0);
        chk("t4_full_req", 32'(s_req), 32'd0);
        chk("t4_full_occ", 32'(outstanding), 32'd2);
        drive(0, 2'b01, 1, 0, 0);
        drive(0, 2'b01, 1, 0, 0);
        drive(0, 2'b01, 1, 1, 32'h4444_0001);
        chk("t4_pop_rvalid", 32'(m_rvalid), 32'h1);
        chk("t4_pop_req", 32'(s_req), 32'd0);
        drive(0, 2'b01, 1, 0, 0);
        chk("t4_occ1", 32'(outstanding), 32'd1);
        chk("t4_reassert", 32'(s_req), 32'd1);
        drive(0, 2'b00, 0, 1, 32'h4444_0002);
        drive(0, 2'b00, 0, 1, 32'h4444_0003);
        drive(0, 2'b00, 0, 0, 0);
        chk("t4_drained", 32'(outstanding), 32'd0);

        // Stray rvalid with an empty FIFO
        drive(0, 2'b00, 0, 1, 32'h5555_5555);
        chk("t5_rvalid", 32'(m_rvalid), 32'h0);
        drive(0, 2'b00, 0, 0, 0);
        chk("t5_err", 32'(rvalid_err), 32'd1);
        drive(0, 2'b00, 0, 0, 0);
        chk("t5_sticky", 32'(rvalid_err), 32'd1);
        drive(1, 2'b00, 0, 0, 0);
        drive(0, 2'b00, 0, 0, 0);
        chk("t5_cleared", 32'(rvalid_err), 32'd0);

        // Reset with two transactions in flight
        drive(0, 2'b01, 1, 0, 0);
        drive(0, 2'b01, 1, 0, 0);
        drive(1, 2'b00, 0, 1, 32'h6666_0001);
        chk("t6_rst_occ", 32'(outstanding), 32'd2);
        chk("t6_rst_rvalid", 32'(m_rvalid), 32'h0);
        drive(0, 2'b00, 0, 1, 32'h6666_0002);
        chk("t6_occ", 32'(outstanding), 32'd0);
        chk("t6_rvalid", 32'(m_rvalid), 32'h0);
        drive(0, 2'b00, 0, 0, 0);
        chk("t6_err", 32'(rvalid_err), 32'd1);

        // Locked master withdraws its request
        drive(0, 2'b10, 0, 0, 0);
        chk("t7_lock_req", 32'(s_req), 32'd1);
        drive(0, 2'b01, 1, 0, 0);
        chk("t7_drop_req", 32'(s_req), 32'd0);
        chk("t7_drop_gnt", 32'(m_gnt), 32'h0);
        drive(0, 2'b01, 1, 0, 0);
        chk("t7_m0_gnt", 32'(m_gnt), 32'h1);
        drive(0, 2'b00, 0, 1, 32'h7777_0001);
        chk("t7_rvalid", 32'(m_rvalid), 32'h1);
        drive(0, 2'b00, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/obi_core_port_arbiter.md
Name: obi_core_port_arbiter

Overview:
- Shares one OBI slave port between the CPU instruction master (M0) and the CPU data master (M1).
- Sits between the cpu subsystem's two OBI masters and a single-ported bus or memory target.
- Arbitrates the address phase using round-robin with a request lock.
- Tracks outstanding transactions in an in-order ID FIFO and routes each response phase back to the master that issued it.

Parameters:
- MAX_OUTSTANDING, 2: depth of the in-order ID FIFO, i.e. the number of accepted transactions awaiting rvalid. Legal range 1..8; power of two not required.
- FIXED_PRIO, 0: 0 selects round-robin; 1 selects fixed priority where M1 (data) always wins.

Ports:
- clk_i in 1: clock.
- rst_i in 1: synchronous reset, active-high.
- m_req_i in 2: per-master request; bit 0 is M0 (instr), bit 1 is M1 (data).
- m_addr_i in 2x32: per-master address.
- m_we_i in 2: per-master write enable.
- m_be_i in 2x4: per-master byte enables.
- m_wdata_i in 2x32: per-master write data.
- m_gnt_o out 2: per-master grant.
- m_rvalid_o out 2: per-master response valid.
- m_rdata_o out 32: response data, broadcast to both masters; qualified by m_rvalid_o.
- s_req_o out 1: slave request.
- s_addr_o out 32: slave address.
- s_we_o out 1: slave write enable.
- s_be_o out 4: slave byte enables.
- s_wdata_o out 32: slave write data.
- s_gnt_i in 1: slave grant.
- s_rvalid_i in 1: slave response valid.
- s_rdata_i in 32: slave response data.
- outstanding_o out 4: current ID FIFO occupancy.
- rvalid_err_o out 1: sticky flag, set by an rvalid that arrives with no outstanding transaction.

Behaviour:
- Reset (rst_i high at a clock edge):
  - ID FIFO empties; outstanding_o=0.
  - Lock clears.
  - Round-robin last-winner register is set to M1, so M0 wins the first tie.
  - rvalid_err_o=0.
  - While rst_i is high, all of m_gnt_o, m_rvalid_o, s_req_o are forced 0.
- Reset mid-transaction: in-flight IDs are discarded. Any s_rvalid_i during or after reset for those transactions is treated as the empty-FIFO case below.
- Address phase is combinational, with zero added latency:
  - s_req_o = (any selected m_req_i) AND NOT fifo_full.
  - s_addr_o, s_we_o, s_be_o and s_wdata_o are muxed from the selected master.
- Grant: m_gnt_o[sel] = s_gnt_i AND s_req_o. The non-selected master's gnt is 0.
- Handshake: s_req_o AND s_gnt_i in the same cycle. On a handshake:
  - push sel into the ID FIFO;
  - update last-winner to sel;
  - clear the lock.
- Selection with no lock active:
  - Exactly one requester: that master is selected.
  - Both requesting, round-robin: the master that is not last-winner is selected.
  - Both requesting, FIXED_PRIO=1: M1 is selected.
- Lock: if s_req_o=1 and s_gnt_i=0, register lock=1 and locked_sel=sel. While locked, sel=locked_sel regardless of the other master, which keeps the address phase stable per OBI.
- Locked master drops m_req_i (protocol violation): clear the lock next cycle. s_req_o follows m_req_i[locked_sel], i.e. 0.
- FIFO full (occupancy == MAX_OUTSTANDING):
  - s_req_o=0 and no gnt, even if s_rvalid_i pops in the same cycle. There is no combinational path from rvalid to req.
  - The lock state is held unchanged.
- Response phase is combinational:
  - When s_rvalid_i=1 and the FIFO is non-empty: m_rvalid_o[head]=1, m_rdata_o=s_rdata_i, and the FIFO pops.
  - m_rdata_o = s_rdata_i at all times.
- Simultaneous push and pop (FIFO not full): both happen; occupancy is unchanged.
  - The push is ordered after the pop, so a newly granted ID is never the head consumed in the same cycle.
  - The slave must not return rvalid in the grant cycle (OBI minimum one-cycle response latency).
- s_rvalid_i with the FIFO empty: no m_rvalid_o, no pop, rvalid_err_o sets and stays set until reset.
- FIFO implementation:
  - Read and write pointers wrap modulo MAX_OUTSTANDING.
  - A separate count register distinguishes full from empty.
  - outstanding_o = count, zero-extended to 4 bits.

Test Plan:
1. Reset, then M0 only, addr 0x180; slave gnt is immediate and rvalid comes 1 cycle later with rdata 0xDEADBEEF → m_gnt_o=01 in cycle 0, m_rvalid_o=01 in cycle 1 with m_rdata_o=0xDEADBEEF, and outstanding_o goes 0→1→0.
2. Both masters request continuously with s_gnt_i=1 and rvalid 1 cycle later, FIXED_PRIO=0 → grants alternate M0,M1,M0,M1, and each rvalid is routed to the matching master in grant order.
3. M1 write addr 0x2000, s_gnt_i held 0 for 3 cycles while M0 also requests → s_addr_o stays 0x2000 with we=1 throughout, M0 is not granted, and M1 is granted in the 4th cycle.
4. MAX_OUTSTANDING=2, slave grants but delays rvalid by 5 cycles → after 2 grants s_req_o=0 and outstanding_o=2. The first rvalid pops to 1, and s_req_o reasserts the following cycle.
5. s_rvalid_i pulse with an empty FIFO → m_rvalid_o=00 and rvalid_err_o=1, which stays set until rst_i.
6. rst_i asserted with 2 transactions outstanding, then s_rvalid_i after reset → outstanding_o=0, m_rvalid_o=00, rvalid_err_o=1.
